// File: rtl/wb_prefetch_pkg.sv
// rtl/wb_prefetch_pkg.sv - shared types and constants for the Wishbone instruction prefetcher
package wb_prefetch_pkg;

    localparam int PF_AW = 32;
    localparam int PF_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } pf_state_t;

    // Queue entry layout; the top packs its FIFO words in this same order.
    typedef struct packed {
        logic [PF_AW-1:0] pc;
        logic [PF_DW-1:0] insn;
        logic             err;
    } pf_entry_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hf;

endpackage

// File: rtl/wb_prefetch_fifo.sv
// rtl/wb_prefetch_fifo.sv - synchronous FIFO with flush; head entry visible combinationally
module wb_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != FULL_C);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_prefetch.sv
// rtl/wb_prefetch.sv - Wishbone classic single-read instruction prefetcher with redirect/flush
module wb_prefetch
    import wb_prefetch_pkg::*;
#(
    parameter int             AW       = 32,
    parameter int             DW       = 32,
    parameter int             DEPTH    = 4,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_i,
    input  logic [AW-1:0] redirect_pc_i,
    output logic          fetch_valid_o,
    input  logic          fetch_ready_i,
    output logic [AW-1:0] fetch_pc_o,
    output logic [DW-1:0] fetch_insn_o,
    output logic          fetch_err_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [DW-1:0] wbm_dat_o,
    output logic          wbm_we_o,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    input  logic [DW-1:0] wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    input  logic          wbm_rty_i
);

    localparam int EW = AW + DW + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    pf_state_t      state;
    logic [AW-1:0]  next_pc;
    logic [AW-1:0]  adr;
    logic           cyc;
    logic           halted;

    logic [CW-1:0]  count;
    logic           empty;
    logic [EW-1:0]  head;
    logic [EW-1:0]  push_data;
    logic           push;
    logic           term;
    logic           outstanding;
    logic           can_issue;
    logic [AW-1:0]  redir_pc;
    logic           unused_redirect_lsbs;

    assign term        = wbm_ack_i | wbm_err_i | wbm_rty_i;
    assign outstanding = (state != IDLE);
    assign redir_pc    = {redirect_pc_i[AW-1:2], 2'b00};
    assign unused_redirect_lsbs = &{1'b0, redirect_pc_i[1:0]};

    // Credit check: an accepted response must always find a free slot.
    assign can_issue = !halted && ((count + CW'(outstanding)) < DEPTH_C);

    assign push      = (state == REQ) && term && !redirect_i && (wbm_ack_i || wbm_err_i);
    assign push_data = wbm_ack_i ? {next_pc, wbm_dat_i, 1'b0} : {next_pc, {DW{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cyc     <= 1'b0;
            adr     <= RESET_PC;
            next_pc <= RESET_PC;
            halted  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_i) begin
                        next_pc <= redir_pc;
                        halted  <= 1'b0;
                    end else if (can_issue) begin
                        state <= REQ;
                        cyc   <= 1'b1;
                        adr   <= next_pc;
                    end
                end
                REQ: begin
                    if (term) begin
                        state <= IDLE;
                        cyc   <= 1'b0;
                        if (redirect_i) begin
                            next_pc <= redir_pc;
                            halted  <= 1'b0;
                        end else if (wbm_ack_i) begin
                            next_pc <= next_pc + AW'(4);
                        end else if (wbm_err_i) begin
                            halted <= 1'b1;
                        end
                    end else if (redirect_i) begin
                        // Cannot abandon a classic cycle; wait out the orphan in DROP.
                        state   <= DROP;
                        next_pc <= redir_pc;
                        halted  <= 1'b0;
                    end
                end
                DROP: begin
                    if (redirect_i) begin
                        next_pc <= redir_pc;
                    end
                    if (term) begin
                        state <= IDLE;
                        cyc   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cyc   <= 1'b0;
                end
            endcase
        end
    end

    wb_prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_data),
        .pop       (fetch_valid_o && fetch_ready_i),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    assign fetch_valid_o = !empty;
    assign {fetch_pc_o, fetch_insn_o, fetch_err_o} = head;

    assign wbm_adr_o = adr;
    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_dat_o = '0;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = WB_SEL_ALL;

endmodule

// File: tb/tb_wb_prefetch.sv
// tb/tb_wb_prefetch.sv - scoreboard bench for wb_prefetch against a bootrom-style slave
module tb_wb_prefetch;
    import wb_prefetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_ready = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_insn;
    logic        fetch_err;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_o;
    logic        wbm_we;
    logic [3:0]  wbm_sel;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack = 1'b0;
    logic        wbm_err = 1'b0;
    logic        wbm_rty = 1'b0;

    logic        err_en = 1'b0;
    logic [31:0] err_adr = '0;
    logic        rty_arm = 1'b0;
    logic        rty_used = 1'b0;
    logic [31:0] rty_adr = '0;

    int cycle = 0;
    int n_req = 0;
    int n_adr4 = 0;
    logic stb_d = 1'b0;
    int n_pops = 0;
    int n_total = 0;
    int n_pass = 0;
    logic [64:0] exp_q [$];

    always #5 clk = ~clk;

    wb_prefetch u_dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .fetch_valid_o (fetch_valid),
        .fetch_ready_i (fetch_ready),
        .fetch_pc_o    (fetch_pc),
        .fetch_insn_o  (fetch_insn),
        .fetch_err_o   (fetch_err),
        .wbm_adr_o     (wbm_adr),
        .wbm_dat_o     (wbm_dat_o),
        .wbm_we_o      (wbm_we),
        .wbm_sel_o     (wbm_sel),
        .wbm_cyc_o     (wbm_cyc),
        .wbm_stb_o     (wbm_stb),
        .wbm_dat_i     (wbm_dat_i),
        .wbm_ack_i     (wbm_ack),
        .wbm_err_i     (wbm_err),
        .wbm_rty_i     (wbm_rty)
    );

    assign wbm_dat_i = 32'hA000_0000 + (wbm_adr >> 2);

    always @(posedge clk) begin
        if (wbm_stb && !wbm_ack && !wbm_err && !wbm_rty) begin
            if (err_en && wbm_adr == err_adr) begin
                wbm_err <= 1'b1;
            end else if (rty_arm && !rty_used && wbm_adr == rty_adr) begin
                wbm_rty  <= 1'b1;
                rty_used <= 1'b1;
            end else begin
                wbm_ack <= 1'b1;
            end
        end else begin
            wbm_ack <= 1'b0;
            wbm_err <= 1'b0;
            wbm_rty <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cycle <= cycle + 1;
        stb_d <= wbm_stb;
        if (wbm_stb && !stb_d) begin
            n_req <= n_req + 1;
            if (wbm_adr == 32'h4) n_adr4 <= n_adr4 + 1;
        end
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [64:0] ent(input logic [31:0] pc, input logic [31:0] insn, input logic err);
        return {pc, insn, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target, input string name);
        int k = 0;
        while (n_pops < target && k < 300) begin
            tick();
            k++;
        end
        check(name, 65'(n_pops >= target), 65'(1));
    endtask

    // Monitor: every accepted head is compared against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (fetch_valid && fetch_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pop: got pc 0x%0h insn 0x%0h err %0d, expected nothing",
                             fetch_pc, fetch_insn, fetch_err);
                end else begin
                    check("fetch_entry", {fetch_pc, fetch_insn, fetch_err}, exp_q.pop_front());
                end
                n_pops++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int base;
        int p;
        logic found;

        // Reset state
        repeat (3) tick();
        check("rst_cyc", 65'(wbm_cyc), 65'(0));
        check("rst_stb", 65'(wbm_stb), 65'(0));
        check("rst_valid", 65'(fetch_valid), 65'(0));
        check("rst_adr", 65'(wbm_adr), 65'(0));
        check("rst_head", {fetch_pc, fetch_insn, fetch_err}, 65'(0));
        check("rst_sel_we", 65'({wbm_sel, wbm_we}), 65'(5'b11110));

        // 1: sequential fetch with ready high
        exp_q.push_back(ent(32'h0, 32'hA000_0000, 1'b0));
        exp_q.push_back(ent(32'h4, 32'hA000_0001, 1'b0));
        exp_q.push_back(ent(32'h8, 32'hA000_0002, 1'b0));
        p = n_pops;
        fetch_ready = 1'b1;
        rst = 1'b0;
        t0 = -100;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (wbm_stb) begin
                t0 = cycle;
                break;
            end
        end
        t1 = -1000;
        for (int k = 0; k < 20; k++) begin
            if (fetch_valid) begin
                t1 = cycle;
                break;
            end
            tick();
        end
        check("first_latency", 65'(t1 - t0), 65'(2));
        wait_pops(p + 3, "t1_drain");
        fetch_ready = 1'b0;

        // 2: back-pressure fills the queue, then drain and resume
        rst = 1'b1;
        tick(); tick();
        base = n_req;
        rst = 1'b0;
        repeat (40) tick();
        check("fill_reads", 65'(n_req - base), 65'(4));
        check("fill_cyc_idle", 65'(wbm_cyc), 65'(0));
        check("fill_count", 65'(u_dut.u_fifo.count), 65'(4));
        check("fill_valid", 65'(fetch_valid), 65'(1));
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ent(32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0));
        end
        p = n_pops;
        fetch_ready = 1'b1;
        wait_pops(p + 6, "t2_drain");
        fetch_ready = 1'b0;

        // 3: redirect to a misaligned target while a read is outstanding
        rst = 1'b1;
        tick(); tick();
        exp_q.push_back(ent(32'h20, 32'hA000_0008, 1'b0));
        exp_q.push_back(ent(32'h24, 32'hA000_0009, 1'b0));
        p = n_pops;
        fetch_ready = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (wbm_stb) break;
        end
        check("redir_in_req", 65'({wbm_stb, wbm_ack}), 65'(2'b10));
        redirect = 1'b1;
        redirect_pc = 32'h23;
        tick();
        redirect = 1'b0;
        check("redir_drop_state", 65'(u_dut.state), 65'(DROP));
        for (int k = 0; k < 20 && wbm_cyc; k++) tick();
        for (int k = 0; k < 20 && !wbm_cyc; k++) tick();
        check("redir_adr", 65'(wbm_adr), 65'(32'h20));
        wait_pops(p + 2, "t3_drain");
        fetch_ready = 1'b0;

        // 4: bus error halts fetching until a redirect
        rst = 1'b1;
        tick(); tick();
        err_en = 1'b1;
        err_adr = 32'h8;
        exp_q.push_back(ent(32'h0, 32'hA000_0000, 1'b0));
        exp_q.push_back(ent(32'h4, 32'hA000_0001, 1'b0));
        exp_q.push_back(ent(32'h8, 32'h0, 1'b1));
        base = n_req;
        p = n_pops;
        fetch_ready = 1'b1;
        rst = 1'b0;
        wait_pops(p + 3, "t4_drain");
        repeat (10) tick();
        check("err_reads", 65'(n_req - base), 65'(3));
        check("err_halt_cyc", 65'(wbm_cyc), 65'(0));
        check("err_empty", 65'(fetch_valid), 65'(0));
        err_en = 1'b0;
        exp_q.push_back(ent(32'h0, 32'hA000_0000, 1'b0));
        exp_q.push_back(ent(32'h4, 32'hA000_0001, 1'b0));
        p = n_pops;
        redirect = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        wait_pops(p + 2, "t4_resume");
        fetch_ready = 1'b0;

        // 5: retry on the first read of 0x4
        rst = 1'b1;
        tick(); tick();
        rty_arm = 1'b1;
        rty_adr = 32'h4;
        exp_q.push_back(ent(32'h0, 32'hA000_0000, 1'b0));
        exp_q.push_back(ent(32'h4, 32'hA000_0001, 1'b0));
        exp_q.push_back(ent(32'h8, 32'hA000_0002, 1'b0));
        base = n_adr4;
        p = n_pops;
        fetch_ready = 1'b1;
        rst = 1'b0;
        wait_pops(p + 3, "t5_drain");
        fetch_ready = 1'b0;
        check("rty_reissue", 65'(n_adr4 - base), 65'(2));
        check("rty_seen", 65'(rty_used), 65'(1));

        // 6: reset with three queued words and a read outstanding
        rst = 1'b1;
        tick(); tick();
        base = n_req;
        rst = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (n_req - base == 4 && wbm_stb) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_setup", 65'(found), 65'(1));
        check("t6_pre_count", 65'(u_dut.u_fifo.count), 65'(3));
        rst = 1'b1;
        tick();
        check("t6_rst_cyc", 65'(wbm_cyc), 65'(0));
        check("t6_rst_valid", 65'(fetch_valid), 65'(0));
        rst = 1'b0;
        exp_q.push_back(ent(32'h0, 32'hA000_0000, 1'b0));
        exp_q.push_back(ent(32'h4, 32'hA000_0001, 1'b0));
        p = n_pops;
        fetch_ready = 1'b1;
        for (int k = 0; k < 20 && !wbm_stb; k++) tick();
        check("t6_restart_adr", 65'(wbm_adr), 65'(0));
        wait_pops(p + 2, "t6_drain");
        fetch_ready = 1'b0;

        repeat (5) tick();
        check("queue_empty", 65'(exp_q.size()), 65'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
